cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run-control sequencer for the verifuck CPU core. It replaces the free-running divided CPU clock with a single-cycle clock-enable pulse (`cpu_ce`) generated on the system clock, at a programmable rate. It adds halt, run and single-step commands, honours CPU-originated halt and stall requests, and counts issued steps. It sits in `top` between the command source (UART debug decoder or buttons) and the CPU's clock-enable input.

## Interface
- `DIV_WIDTH`, 16: width of the divider register and counter.
- `DEFAULT_DIV`, 31: divider value loaded at reset. `cpu_ce` period is DIV+1 clk cycles, so 31 gives one pulse every 32 cycles.
- `AUTO_RUN`, 1: state after reset. 1 = RUNNING, 0 = HALTED.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on a clk edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 2: command opcode. 0 = HALT, 1 = RUN, 2 = STEP, 3 = SET_DIV.
- `cmd_div` in DIV_WIDTH: new divider value; used only by SET_DIV.
- `cpu_halt_req` in 1: level from the CPU requesting a stop (end of program or breakpoint).
- `cpu_stall` in 1: CPU waiting on I/O; freezes the divider.
- `cpu_ce` out 1: one-cycle clock-enable pulse to the CPU.
- `state` out 2: current state. 0 = HALTED, 1 = RUNNING, 2 = STEP.
- `halted_by_cpu` out 1: sticky flag; the last stop was caused by `cpu_halt_req`.
- `ce_count` out 32: number of `cpu_ce` pulses issued; wraps modulo 2^32.

## Operation
- **Registers:** `div_reg` (DIV_WIDTH bits), `div_cnt` (DIV_WIDTH bits), `state`, `cpu_ce`, `halted_by_cpu`, `ce_count`.
- **Reset values:**
  - `state` = AUTO_RUN ? RUNNING : HALTED
  - `div_reg` = DEFAULT_DIV
  - `div_cnt` = 0
  - `cpu_ce` = 0
  - `halted_by_cpu` = 0
  - `ce_count` = 0
  - `cmd_ready` = 1
- **cmd_ready:** combinational, equal to `state != STEP`.
- **Tick:** tick = (`state` is RUNNING or STEP) && !`cpu_stall` && (`div_cnt == div_reg`).
  - On a tick: `div_cnt` <= 0, `cpu_ce` <= 1, `ce_count` increments.
  - Otherwise, in RUNNING or STEP with `cpu_stall` = 0: `div_cnt` increments and `cpu_ce` <= 0.
  - With `cpu_stall` = 1: `div_cnt` holds and `cpu_ce` <= 0.
  - In HALTED: `div_cnt` holds 0 and `cpu_ce` <= 0.
- **HALTED state:**
  - RUN → RUNNING, `div_cnt` <= 0, `halted_by_cpu` <= 0.
  - STEP → STEP, `div_cnt` <= 0, `halted_by_cpu` <= 0.
  - HALT is a no-op.
- **RUNNING state:**
  - HALT → HALTED; no pulse is issued on that edge even if a tick was due.
  - `cpu_halt_req` = 1 → HALTED, `halted_by_cpu` <= 1, no pulse on that edge.
  - RUN and STEP are accepted with no effect.
- **STEP state:**
  - On a tick → HALTED, with exactly one `cpu_ce` pulse issued.
  - `cpu_halt_req` = 1 → HALTED, `halted_by_cpu` <= 1, no pulse.
  - No commands are accepted in this state.
- **SET_DIV (HALTED or RUNNING):** `div_reg` <= `cmd_div`, `div_cnt` <= 0, state unchanged. No pulse is issued on the accepting edge.
- **Priority on one edge:** `rst` > `cpu_halt_req` (RUNNING/STEP) > accepted command > tick.
- **Arithmetic:** `div_cnt` and `div_reg` are unsigned. `div_cnt` can never exceed `div_reg`, because SET_DIV clears `div_cnt`. `ce_count` wraps from 0xFFFFFFFF to 0.

## Timing
- `cpu_ce` is registered and high for exactly one clk cycle per tick.
- RUN or STEP accepted at edge N gives the first pulse high between edge N+D+1 and edge N+D+2, where D = `div_reg`. Later pulses in RUNNING follow every D+1 edges.
- D = 0: `cpu_ce` stays high on consecutive cycles while RUNNING and not stalled.
- Stall: each stalled cycle delays the next pulse by one cycle. A pulse already registered (high in the current cycle) is not retracted.
- HALT or `cpu_halt_req` sampled at edge M: no pulse goes high after edge M, and `state` reads HALTED after edge M.
- `rst` asserted mid-operation: all registers take their reset values at the next edge, and a `cpu_ce` already high drops after that edge.
- STEP: `cmd_ready` is low from the accepting edge until the edge that issues the pulse.

## Test plan
- **Reset run:** `rst` high 2 cycles, AUTO_RUN = 1, DEFAULT_DIV = 31, idle for 200 cycles → `cpu_ce` pulses one cycle wide every 32 cycles, the first one 32 edges after reset release; `ce_count` = 6.
- **Halt/step:** HALT, then STEP with D = 3 → `state` = STEP, `cmd_ready` = 0, exactly one pulse 4 edges after acceptance, then HALTED; `ce_count` +1 and no further pulses for 100 cycles.
- **SET_DIV 0 while running:** `cpu_ce` high continuously; then `cpu_stall` high for 5 cycles → `cpu_ce` low for exactly 5 cycles and `ce_count` frozen during the stall.
- **CPU halt coinciding with a due tick:** `cpu_halt_req` pulsed on the edge where `div_cnt == div_reg` → no pulse on that edge, `state` = HALTED, `halted_by_cpu` = 1; a following RUN clears `halted_by_cpu` to 0.
- **Wrap and mid-operation reset:** force `ce_count` to 0xFFFFFFFE with D = 0, run 3 cycles → `ce_count` goes 0xFFFFFFFF, 0, 1. Assert `rst` during STEP → `state` = RUNNING, `cmd_ready` = 1, `div_reg` = 31.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the CPU core. It turns a programmable-rate divider into
// single-cycle clock-enable pulses, and it supports halt, run, single-step and CPU-initiated stops.
module cpu_run_ctrl #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 31,
    parameter bit          AUTO_RUN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [DIV_WIDTH-1:0] cmd_div,
    input  logic                 cpu_halt_req,
    input  logic                 cpu_stall,
    output logic                 cpu_ce,
    output logic [1:0]           state,
    output logic                 halted_by_cpu,
    output logic [31:0]          ce_count
);

    localparam logic [1:0] ST_HALTED  = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;

    localparam logic [1:0] OP_HALT    = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_STEP    = 2'd2;
    localparam logic [1:0] OP_SET_DIV = 2'd3;

    localparam logic [1:0]           ST_RESET  = AUTO_RUN ? ST_RUNNING : ST_HALTED;
    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = '0;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 ce_q, ce_d;
    logic                 hbc_q, hbc_d;
    logic [31:0]          ce_count_q, ce_count_d;

    logic active;
    logic cmd_fire;
    logic cmd_halt;
    logic cmd_go;
    logic cmd_set_div;
    logic halt_stop;
    logic tick;
    logic issue;

    // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on state, never on cmd_valid.
    assign cmd_ready   = (state_q != ST_STEP);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign cmd_halt    = cmd_fire && (cmd_op == OP_HALT);
    assign cmd_go      = cmd_fire && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP));
    assign cmd_set_div = cmd_fire && (cmd_op == OP_SET_DIV);

    assign active    = (state_q == ST_RUNNING) || (state_q == ST_STEP);
    assign halt_stop = active && cpu_halt_req;
    assign tick      = active && !cpu_stall && (div_cnt_q == div_reg_q);

    // A CPU stop, a HALT or a divider reload on the same edge suppresses a due pulse.
    assign issue = tick && !halt_stop && !cmd_halt && !cmd_set_div;

    assign cpu_ce        = ce_q;
    assign state         = state_q;
    assign halted_by_cpu = hbc_q;
    assign ce_count      = ce_count_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALTED: begin
                if (cmd_fire && (cmd_op == OP_RUN)) begin
                    state_d = ST_RUNNING;
                end else if (cmd_fire && (cmd_op == OP_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUNNING: begin
                if (halt_stop || cmd_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (halt_stop || tick) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        div_reg_d  = div_reg_q;
        div_cnt_d  = div_cnt_q;
        ce_d       = 1'b0;
        hbc_d      = hbc_q;
        ce_count_d = ce_count_q;

        if (!active) begin
            div_cnt_d = DIV_ZERO;
            if (cmd_go) begin
                hbc_d = 1'b0;
            end
            if (cmd_set_div) begin
                div_reg_d = cmd_div;
            end
        end else if (halt_stop) begin
            hbc_d     = 1'b1;
            div_cnt_d = DIV_ZERO;
        end else if (cmd_halt) begin
            div_cnt_d = DIV_ZERO;
        end else if (cmd_set_div) begin
            div_reg_d = cmd_div;
            div_cnt_d = DIV_ZERO;
        end else if (issue) begin
            div_cnt_d  = DIV_ZERO;
            ce_d       = 1'b1;
            ce_count_d = ce_count_q + 32'd1;
        end else if (!cpu_stall) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg_q  <= DIV_RESET;
            div_cnt_q  <= DIV_ZERO;
            ce_q       <= 1'b0;
            hbc_q      <= 1'b0;
            ce_count_q <= 32'd0;
        end else begin
            div_reg_q  <= div_reg_d;
            div_cnt_q  <= div_cnt_d;
            ce_q       <= ce_d;
            hbc_q      <= hbc_d;
            ce_count_q <= ce_count_d;
        end
    end

    // The counter is cleared whenever the divider changes, so it never passes div_reg.
    a_cnt_bounded: assert property (@(posedge clk) disable iff (rst) div_cnt_q <= div_reg_q);
    a_state_legal: assert property (@(posedge clk) disable iff (rst) state_q != 2'd3);

endmodule
